// File: rtl/datamem_mmio_responder_if.sv
// Data-memory bus between the single-cycle core (master) and the memory responder (slave).
interface datamem_mmio_responder_if;
  logic        memwrite;
  logic        memread;
  logic [2:0]  memop;
  logic [8:0]  memaddr;
  logic [31:0] memdatain;
  logic [31:0] memdataout;

  modport master (
    output memwrite,
    output memread,
    output memop,
    output memaddr,
    output memdatain,
    input  memdataout
  );

  modport slave (
    input  memwrite,
    input  memread,
    input  memop,
    input  memaddr,
    input  memdatain,
    output memdataout
  );
endinterface

// File: rtl/datamem_mmio_responder.sv
// Data RAM plus a 16-byte MMIO window (cycle counter, compare timer, sticky status, GPIO).
// Loads are combinational; every state update happens on the rising clock edge.
module datamem_mmio_responder #(
  parameter int unsigned RAM_WORDS = 124,
  parameter logic [8:0]  MMIO_BASE = 9'h1F0
) (
  input  logic                        clk,
  input  logic                        rst,
  datamem_mmio_responder_if.slave     bus,
  output logic                        irq,
  output logic [7:0]                  gpio_out,
  output logic                        misalign
);

  localparam int unsigned RamBytes = RAM_WORDS * 4;

  localparam logic [2:0] OpLb  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLw  = 3'b010;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpLhu = 3'b101;

  // MMIO register select (word offset within the window)
  localparam logic [1:0] RegCount   = 2'd0;
  localparam logic [1:0] RegCompare = 2'd1;
  localparam logic [1:0] RegStatus  = 2'd2;
  localparam logic [1:0] RegGpio    = 2'd3;

  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] ram_d [RAM_WORDS];
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  gpio_q, gpio_d;

  logic        is_byte, is_half, is_word, op_legal;
  logic        in_mmio, in_ram, misaligned;
  logic [9:0]  addr_ext, base_ext;
  logic [6:0]  word_idx;
  logic [1:0]  reg_sel;
  logic [31:0] rd_word;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        wr_ok, timer_set, mis_set;
  logic [3:0]  wmask;
  logic [31:0] wdata;

  // Address/op decode and legality
  always_comb begin
    is_byte    = (bus.memop == OpLb) || (bus.memop == OpLbu);
    is_half    = (bus.memop == OpLh) || (bus.memop == OpLhu);
    is_word    = (bus.memop == OpLw);
    op_legal   = is_byte || is_half || is_word;
    addr_ext   = {1'b0, bus.memaddr};
    base_ext   = {1'b0, MMIO_BASE};
    // Widened compare so a window ending at 0x200 does not wrap
    in_mmio    = (addr_ext >= base_ext) && (addr_ext < base_ext + 10'd16);
    in_ram     = !in_mmio && (32'(bus.memaddr) < RamBytes);
    word_idx   = bus.memaddr[8:2];
    reg_sel    = bus.memaddr[3:2];
    misaligned = !op_legal
               || (is_half && bus.memaddr[0])
               || (is_word && (bus.memaddr[1:0] != 2'b00))
               || (in_mmio && !is_word);
  end

  // Combinational load path: fetch word, pick lane(s), extend
  always_comb begin
    rd_word = '0;
    if (in_ram) begin
      rd_word = ram_q[word_idx];
    end else if (in_mmio) begin
      unique case (reg_sel)
        RegCount:   rd_word = count_q;
        RegCompare: rd_word = compare_q;
        RegStatus:  rd_word = {30'b0, status_q};
        RegGpio:    rd_word = {24'b0, gpio_q};
        default:    rd_word = '0;
      endcase
    end
    unique case (bus.memaddr[1:0])
      2'd0:    lane_byte = rd_word[7:0];
      2'd1:    lane_byte = rd_word[15:8];
      2'd2:    lane_byte = rd_word[23:16];
      default: lane_byte = rd_word[31:24];
    endcase
    lane_half = bus.memaddr[1] ? rd_word[31:16] : rd_word[15:0];
    bus.memdataout = '0;
    if (bus.memread && !misaligned) begin
      case (bus.memop)
        OpLb:    bus.memdataout = {{24{lane_byte[7]}}, lane_byte};
        OpLh:    bus.memdataout = {{16{lane_half[15]}}, lane_half};
        OpLw:    bus.memdataout = rd_word;
        OpLbu:   bus.memdataout = {24'b0, lane_byte};
        OpLhu:   bus.memdataout = {16'b0, lane_half};
        default: bus.memdataout = '0;
      endcase
    end
  end

  // Next-state for RAM and MMIO registers
  always_comb begin
    wr_ok = bus.memwrite && !misaligned;
    if (is_word) begin
      wmask = 4'b1111;
      wdata = bus.memdatain;
    end else if (is_half) begin
      wmask = bus.memaddr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{bus.memdatain[15:0]}};
    end else begin
      wmask = 4'b0001 << bus.memaddr[1:0];
      wdata = {4{bus.memdatain[7:0]}};
    end

    ram_d = ram_q;
    if (wr_ok && in_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) ram_d[word_idx][8*i +: 8] = wdata[8*i +: 8];
      end
    end

    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    status_d  = status_q;
    gpio_d    = gpio_q;
    if (wr_ok && in_mmio) begin
      unique case (reg_sel)
        RegCount:   count_d   = bus.memdatain;  // CPU load replaces this edge's increment
        RegCompare: compare_d = bus.memdatain;
        RegStatus:  status_d  = status_q & ~bus.memdatain[1:0];
        RegGpio:    gpio_d    = bus.memdatain[7:0];
        default:    ;
      endcase
    end

    // Sets applied after W1C so a coincident set wins
    timer_set = (count_q == compare_q) && (compare_q != 32'd0);
    mis_set   = (bus.memread || bus.memwrite) && misaligned;
    status_d  = status_d | {mis_set, timer_set};
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_q     <= '{default: '0};
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= '0;
      gpio_q    <= '0;
    end else begin
      ram_q     <= ram_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      gpio_q    <= gpio_d;
    end
  end

  assign irq      = status_q[0];
  assign misalign = status_q[1];
  assign gpio_out = gpio_q;

endmodule

// File: doc/datamem_mmio_responder.md
Name: datamem_mmio_responder

Overview:
- Responder end of the CPU data-memory bus (memwrite/memread/memop/memaddr/memdatain/memdataout) for the single-cycle core.
- Serves byte, half and word loads and stores into a 496-byte data RAM.
- Decodes a 16-byte MMIO window holding a free-running cycle counter, a compare/interrupt timer, a sticky status register and an 8-bit GPIO output.
- Reads are combinational, as the single-cycle datapath requires; all state updates on the rising clock edge.

Parameters:
RAM_WORDS, 124, number of 32-bit RAM words; byte addresses 0x000..0x1EF
MMIO_BASE, 9'h1F0, byte address of the MMIO window (16 bytes, 4 word registers)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
memwrite  input  1  store request, committed at the next rising clk edge
memread  input  1  load request, combinational
memop  input  3  000 signed byte, 001 signed half, 010 word, 100 unsigned byte, 101 unsigned half; other codes are illegal
memaddr  input  9  byte address
memdatain  input  32  store data (CPU to memory), right-aligned
memdataout  output  32  load data (memory to CPU), extended per memop
irq  output  1  timer-match sticky flag (status bit0)
gpio_out  output  8  GPIO register low byte
misalign  output  1  misalignment sticky flag (status bit1)

Behaviour:
- Reset, asynchronous: all RAM words = 0, counter = 0, compare = 0, status = 0, gpio = 0. Outputs irq = 0, misalign = 0, gpio_out = 0. memdataout is 0 while memread = 0.
- Little-endian byte lanes. Byte access uses lane memaddr[1:0]. Half access uses lanes {addr[1],0}/{addr[1],1}.
- Access legality:
  - Half access with addr[0] = 1 is misaligned.
  - Word access with addr[1:0] != 0 is misaligned.
  - Any non-word access inside the MMIO window is misaligned.
  - Illegal memop is misaligned.
  - Misaligned store: suppressed, no state change except the sticky flag.
  - Misaligned load: memdataout = 0.
  - In every misaligned case, status bit1 is set at the edge when memread or memwrite = 1.
- RAM load: memdataout = selected lane(s), sign-extended (000/001) or zero-extended (100/101). Word returned as is.
- RAM store: sb/sh write only the addressed lane(s) from memdatain[7:0]/[15:0]; other lanes are unchanged. sw writes all lanes.
- Address beyond RAM and below MMIO_BASE: only when RAM_WORDS is reduced. Reads return 0; writes are ignored; no flag is set.
- MMIO map (word offsets):
  - +0x0 COUNT, RW: increments by 1 every clk, wraps 0xFFFFFFFF to 0. A CPU write loads memdatain, and on that edge the increment is dropped.
  - +0x4 COMPARE, RW.
  - +0x8 STATUS: bit0 timer, bit1 misalign, other bits read 0. Write-1-to-clear.
  - +0xC GPIO, RW: bits[7:0] only, reads zero-extended.
- Timer match:
  - At an edge where COUNT (pre-increment value) == COMPARE and COMPARE != 0, set status bit0.
  - irq = status bit0; misalign = status bit1.
- Simultaneous events:
  - A set event and a W1C clear of the same bit on the same edge: set wins.
  - memread and memwrite both 1: memdataout shows pre-edge contents, and the write commits at the edge.
- Load-after-store latency: a store at edge N is visible combinationally in the cycle after edge N.
- Reset asserted mid-operation clears everything immediately; no store from that cycle commits.

Test Plan:
- After reset, sw 0xDEADBEEF to 0x010. Then lb@0x013 -> 0xFFFFFFDE; lbu@0x013 -> 0x000000DE; lh@0x010 -> 0xFFFFBEEF; lhu@0x012 -> 0x0000DEAD.
- sb 0x55 to 0x011 over 0xDEADBEEF -> lw@0x010 = 0xDEAD55EF. sh 0x1234 to 0x012 -> lw@0x010 = 0x123455EF.
- lh@0x011 and sw@0x012 -> memdataout 0, RAM word unchanged, misalign = 1 after the edge. sw 0x2 to 0x1F8 -> misalign = 0.
- sw COMPARE = 20, sw COUNT = 10 -> irq rises at the edge where COUNT reads 20, stays high. sw 0x1 to 0x1F8 -> irq = 0 unless a match occurs on the same edge.
- Match edge coinciding with W1C of bit0 -> irq stays 1. sw 0xFFFFFFFF to COUNT, one clk -> COUNT reads 0.
- sw 0x1A5 to GPIO -> gpio_out = 0xA5, lw@0x1FC = 0x000000A5. Pulse rst mid-run -> gpio_out, irq, misalign = 0 and lw@0x010 = 0.
